// File: rtl/emu_scan_pkg.sv
// Shared types and defaults for the emulator RAM scan-chain sequencer.
package emu_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_SCAN,
    ST_FLUSH,
    ST_RELEASE
  } scan_state_e;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CHAIN_LEN  = 128;

endpackage

// File: rtl/emu_scan_out_reg.sv
// Single-entry dump output register: captures the chain head whenever the
// slot is empty or being drained, and reports that capture as the shift enable.
module emu_scan_out_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sdo,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  capture
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign capture   = en && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = sdo;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/emu_ram_scan_ctrl.sv
// Emulator RAM scan-chain sequencer: halts the DUT, streams the chain out (dump)
// or in (restore), then releases. Optional checksum port: EMU_RAM_SCAN_CKSUM_EN.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  start_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  emu_halt,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  input  logic [DATA_WIDTH-1:0] ram_sdo,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready
`ifdef EMU_RAM_SCAN_CKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] cksum
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHAIN_LEN - 1);

  scan_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 done_q, done_d;
  logic                 cnt_open, dump_en, capture, in_hs;

  assign cnt_open = (cnt_q < CNT_FULL);
  assign dump_en  = (state_q == ST_SCAN) && (dir_q == DIR_DUMP) && cnt_open;
  assign in_ready = (state_q == ST_SCAN) && (dir_q == DIR_RESTORE) && cnt_open;
  assign in_hs    = in_valid && in_ready;

  emu_scan_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (dump_en),
    .sdo      (ram_sdo),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .capture  (capture)
  );

  // FLUSH shifts a zero word so the chain commits the last restored word.
  assign ram_scan = capture || in_hs || (state_q == ST_FLUSH);
  assign ram_sdi  = in_ready ? in_data : '0;
  assign ram_dir  = dir_q;
  assign emu_halt = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = start_dir;
          cnt_d   = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_SCAN;
      ST_SCAN: begin
        // The last dump word drains during RELEASE, so halt trails scan by one
        // cycle when the store is ready.
        if (capture || in_hs) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = (dir_q == DIR_DUMP) ? ST_RELEASE : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!out_valid || out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

`ifdef EMU_RAM_SCAN_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == ST_IDLE && start) begin
      cksum_d = '0;
    end else if (capture) begin
      cksum_d = cksum_q ^ ram_sdo;
    end else if (in_hs) begin
      cksum_d = cksum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  // Checksum disabled: no extra state or port.
`endif

endmodule
